// File: rtl/dec_stage.sv
// Registered RISC-V decode stage: classifies, range-checks and extracts
// immediates, with a main output register backed by one skid entry.
module dec_stage #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [12:0]     out_cls,
    output logic [XLEN-1:0] out_imm,
    output logic            out_muldiv,
    output logic            out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("dec_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit IS_RV64 = (XLEN == 64);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_OP32     = 5'b01110;

    // Bit positions inside the one-hot class vector.
    localparam int CLS_LOAD     = 0;
    localparam int CLS_STORE    = 1;
    localparam int CLS_BRANCH   = 2;
    localparam int CLS_JALR     = 3;
    localparam int CLS_JAL      = 4;
    localparam int CLS_LUI      = 5;
    localparam int CLS_AUIPC    = 6;
    localparam int CLS_OP_IMM   = 7;
    localparam int CLS_OP       = 8;
    localparam int CLS_SYSTEM   = 9;
    localparam int CLS_MISC_MEM = 10;
    localparam int CLS_OP_IMM32 = 11;
    localparam int CLS_OP32     = 12;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [12:0]     cls;
        logic [XLEN-1:0] imm;
        logic            muldiv;
        logic            illegal;
    } entry_t;

    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        shamt_hi_zero;
    logic        shamt_hi_sra;

    assign opc = in_instr[6:2];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // RV64 shifts have a 6-bit shamt, so only instr[31:26] is the function field.
    assign shamt_hi_zero = IS_RV64 ? (in_instr[31:26] == 6'b000000) : (f7 == F7_ZERO);
    assign shamt_hi_sra  = IS_RV64 ? (in_instr[31:26] == 6'b010000) : (f7 == F7_ALT);

    logic [12:0] dec_cls;
    logic [31:0] dec_imm32;
    logic        dec_illegal;
    logic        dec_muldiv;

    always_comb begin
        dec_cls     = '0;
        dec_imm32   = '0;
        dec_illegal = 1'b0;
        dec_muldiv  = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opc)
                OPC_LOAD: begin
                    dec_cls[CLS_LOAD] = 1'b1;
                    dec_imm32 = imm_i;
                    if (f3 == 3'b111 || (!IS_RV64 && (f3 == 3'b011 || f3 == 3'b110)))
                        dec_illegal = 1'b1;
                end
                OPC_STORE: begin
                    dec_cls[CLS_STORE] = 1'b1;
                    dec_imm32 = imm_s;
                    if (f3[2] || (!IS_RV64 && f3 == 3'b011))
                        dec_illegal = 1'b1;
                end
                OPC_BRANCH: begin
                    dec_cls[CLS_BRANCH] = 1'b1;
                    dec_imm32 = imm_b;
                    if (f3 == 3'b010 || f3 == 3'b011)
                        dec_illegal = 1'b1;
                end
                OPC_JALR: begin
                    dec_cls[CLS_JALR] = 1'b1;
                    dec_imm32 = imm_i;
                    if (f3 != 3'b000)
                        dec_illegal = 1'b1;
                end
                OPC_JAL: begin
                    dec_cls[CLS_JAL] = 1'b1;
                    dec_imm32 = imm_j;
                end
                OPC_LUI: begin
                    dec_cls[CLS_LUI] = 1'b1;
                    dec_imm32 = imm_u;
                end
                OPC_AUIPC: begin
                    dec_cls[CLS_AUIPC] = 1'b1;
                    dec_imm32 = imm_u;
                end
                OPC_OP_IMM: begin
                    dec_cls[CLS_OP_IMM] = 1'b1;
                    dec_imm32 = imm_i;
                    if (f3 == 3'b001 && !shamt_hi_zero)
                        dec_illegal = 1'b1;
                    if (f3 == 3'b101 && !(shamt_hi_zero || shamt_hi_sra))
                        dec_illegal = 1'b1;
                end
                OPC_OP: begin
                    // R-type carries no immediate; out_imm stays zero.
                    dec_cls[CLS_OP] = 1'b1;
                    if (f7 == F7_ZERO) begin
                        dec_illegal = 1'b0;
                    end else if (f7 == F7_ALT) begin
                        if (f3 != 3'b000 && f3 != 3'b101)
                            dec_illegal = 1'b1;
                    end else if (f7 == F7_MUL && EN_M) begin
                        dec_muldiv = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_SYSTEM: begin
                    dec_cls[CLS_SYSTEM] = 1'b1;
                    dec_imm32 = imm_i;
                end
                OPC_MISC_MEM: begin
                    dec_cls[CLS_MISC_MEM] = 1'b1;
                    dec_imm32 = imm_i;
                end
                OPC_OP_IMM32: begin
                    dec_cls[CLS_OP_IMM32] = 1'b1;
                    dec_imm32 = imm_i;
                    if (!IS_RV64)
                        dec_illegal = 1'b1;
                    else if (f3 == 3'b001)
                        dec_illegal = (f7 != F7_ZERO);
                    else if (f3 == 3'b101)
                        dec_illegal = !(f7 == F7_ZERO || f7 == F7_ALT);
                    else if (f3 != 3'b000)
                        dec_illegal = 1'b1;
                end
                OPC_OP32: begin
                    dec_cls[CLS_OP32] = 1'b1;
                    if (!IS_RV64) begin
                        dec_illegal = 1'b1;
                    end else if (f7 == F7_ZERO) begin
                        dec_illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
                    end else if (f7 == F7_ALT) begin
                        dec_illegal = !(f3 == 3'b000 || f3 == 3'b101);
                    end else if (f7 == F7_MUL && EN_M) begin
                        // MULW/DIVW/DIVUW/REMW/REMUW only.
                        dec_muldiv  = 1'b1;
                        dec_illegal = !(f3 == 3'b000 || f3[2]);
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
        if (dec_illegal) begin
            dec_cls    = '0;
            dec_imm32  = '0;
            dec_muldiv = 1'b0;
        end
    end

    entry_t dec_entry;

    always_comb begin
        dec_entry         = '0;
        dec_entry.pc      = in_pc;
        dec_entry.rs1     = in_instr[19:15];
        dec_entry.rs2     = in_instr[24:20];
        dec_entry.rd      = in_instr[11:7];
        dec_entry.funct3  = f3;
        dec_entry.funct7  = f7;
        dec_entry.cls     = dec_cls;
        dec_entry.imm     = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};
        dec_entry.muldiv  = dec_muldiv;
        dec_entry.illegal = dec_illegal;
    end

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   fire;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign fire     = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || fire) begin
            // Skid is older than anything on the input, so it drains first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept)
                    skid_d = dec_entry;
            end else begin
                main_valid_d = accept;
                if (accept)
                    main_d = dec_entry;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_cls     = main_q.cls;
    assign out_imm     = main_q.imm;
    assign out_muldiv  = main_q.muldiv;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: an RV32 (no M) and an RV64 (with M) instance
// share one stimulus stream; decode vectors come from a table, handshake cases are hand-written.
module tb_dec_stage;

    localparam logic [12:0] C_NONE    = 13'h0000;
    localparam logic [12:0] C_LOAD    = 13'h0001;
    localparam logic [12:0] C_STORE   = 13'h0002;
    localparam logic [12:0] C_BRANCH  = 13'h0004;
    localparam logic [12:0] C_JAL     = 13'h0010;
    localparam logic [12:0] C_LUI     = 13'h0020;
    localparam logic [12:0] C_AUIPC   = 13'h0040;
    localparam logic [12:0] C_OPIMM   = 13'h0080;
    localparam logic [12:0] C_OP      = 13'h0100;
    localparam logic [12:0] C_SYSTEM  = 13'h0200;
    localparam logic [12:0] C_MISCMEM = 13'h0400;
    localparam logic [12:0] C_OPIMM32 = 13'h0800;
    localparam logic [12:0] C_OP32    = 13'h1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc32;
    logic [63:0] in_pc64;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_muldiv, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [12:0] a_cls;

    logic        b_in_ready, b_out_valid, b_muldiv, b_illegal;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [12:0] b_cls;

    always #5 clk = ~clk;

    dec_stage #(.XLEN(32), .EN_M(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc32),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_funct3(a_f3), .out_funct7(a_f7), .out_cls(a_cls), .out_imm(a_imm),
        .out_muldiv(a_muldiv), .out_illegal(a_illegal)
    );

    dec_stage #(.XLEN(64), .EN_M(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_funct3(b_f3), .out_funct7(b_f7), .out_cls(b_cls), .out_imm(b_imm),
        .out_muldiv(b_muldiv), .out_illegal(b_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [12:0] cls32;
        logic [31:0] imm32;
        logic        ill32;
        logic        md32;
        logic [12:0] cls64;
        logic [63:0] imm64;
        logic        ill64;
        logic        md64;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] instr, input logic [4:0] rd,
                                 input logic [12:0] c32, input logic [31:0] i32,
                                 input logic il32, input logic m32,
                                 input logic [12:0] c64, input logic [63:0] i64,
                                 input logic il64, input logic m64);
        vec_t v;
        v.instr = instr; v.rd = rd;
        v.cls32 = c32; v.imm32 = i32; v.ill32 = il32; v.md32 = m32;
        v.cls64 = c64; v.imm64 = i64; v.ill64 = il64; v.md64 = m64;
        return v;
    endfunction

    // addi x<k>, x0, k
    function automatic logic [31:0] addi_k(input int k);
        logic [31:0] w;
        w = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr);
        @(negedge clk);
        in_valid = v;
        in_instr = instr;
        in_pc32  = in_pc32 + 32'd4;
        in_pc64  = {32'h0000_0001, in_pc32};
    endtask

    task automatic check_out(input string tag, input logic exp_valid, input int exp_rd,
                             input logic exp_in_ready);
        chk({tag, " out_valid32"}, 64'(a_out_valid), 64'(exp_valid));
        chk({tag, " out_valid64"}, 64'(b_out_valid), 64'(exp_valid));
        chk({tag, " in_ready32"},  64'(a_in_ready), 64'(exp_in_ready));
        if (exp_valid) begin
            chk({tag, " rd32"},  64'(a_rd), 64'(exp_rd));
            chk({tag, " imm32"}, 64'(a_imm), 64'(exp_rd));
            chk({tag, " rd64"},  64'(b_rd), 64'(exp_rd));
        end
    endtask

    vec_t vecs[23];

    initial begin
        vecs[0]  = mkv(32'hFFF00093, 5'd1,  C_OPIMM,  32'hFFFFFFFF, 0, 0, C_OPIMM,   64'hFFFFFFFFFFFFFFFF, 0, 0);
        vecs[1]  = mkv(32'hFE000EE3, 5'd29, C_BRANCH, 32'hFFFFFFFC, 0, 0, C_BRANCH,  64'hFFFFFFFFFFFFFFFC, 0, 0);
        vecs[2]  = mkv(32'h0000303B, 5'd0,  C_NONE,   32'h0,        1, 0, C_NONE,    64'h0,                1, 0);
        vecs[3]  = mkv(32'h02208033, 5'd0,  C_NONE,   32'h0,        1, 0, C_OP,      64'h0,                0, 1);
        vecs[4]  = mkv(32'h123452B7, 5'd5,  C_LUI,    32'h12345000, 0, 0, C_LUI,     64'h0000000012345000, 0, 0);
        vecs[5]  = mkv(32'h800002B7, 5'd5,  C_LUI,    32'h80000000, 0, 0, C_LUI,     64'hFFFFFFFF80000000, 0, 0);
        vecs[6]  = mkv(32'h0040006F, 5'd0,  C_JAL,    32'h00000004, 0, 0, C_JAL,     64'h4,                0, 0);
        vecs[7]  = mkv(32'hFFDFF0EF, 5'd1,  C_JAL,    32'hFFFFFFFC, 0, 0, C_JAL,     64'hFFFFFFFFFFFFFFFC, 0, 0);
        vecs[8]  = mkv(32'h0020A423, 5'd8,  C_STORE,  32'h00000008, 0, 0, C_STORE,   64'h8,                0, 0);
        vecs[9]  = mkv(32'h0020B423, 5'd8,  C_NONE,   32'h0,        1, 0, C_STORE,   64'h8,                0, 0);
        vecs[10] = mkv(32'h00013083, 5'd1,  C_NONE,   32'h0,        1, 0, C_LOAD,    64'h0,                0, 0);
        vecs[11] = mkv(32'hFFF12083, 5'd1,  C_LOAD,   32'hFFFFFFFF, 0, 0, C_LOAD,    64'hFFFFFFFFFFFFFFFF, 0, 0);
        vecs[12] = mkv(32'h02009093, 5'd1,  C_NONE,   32'h0,        1, 0, C_OPIMM,   64'h20,               0, 0);
        vecs[13] = mkv(32'h4030D093, 5'd1,  C_OPIMM,  32'h00000403, 0, 0, C_OPIMM,   64'h403,              0, 0);
        vecs[14] = mkv(32'h00000000, 5'd0,  C_NONE,   32'h0,        1, 0, C_NONE,    64'h0,                1, 0);
        vecs[15] = mkv(32'h00009067, 5'd0,  C_NONE,   32'h0,        1, 0, C_NONE,    64'h0,                1, 0);
        vecs[16] = mkv(32'h00000073, 5'd0,  C_SYSTEM, 32'h0,        0, 0, C_SYSTEM,  64'h0,                0, 0);
        vecs[17] = mkv(32'h0FF0000F, 5'd0,  C_MISCMEM,32'h000000FF, 0, 0, C_MISCMEM, 64'hFF,               0, 0);
        vecs[18] = mkv(32'hFFF0809B, 5'd1,  C_NONE,   32'h0,        1, 0, C_OPIMM32, 64'hFFFFFFFFFFFFFFFF, 0, 0);
        vecs[19] = mkv(32'h403100B3, 5'd1,  C_OP,     32'h0,        0, 0, C_OP,      64'h0,                0, 0);
        vecs[20] = mkv(32'h403110B3, 5'd1,  C_NONE,   32'h0,        1, 0, C_NONE,    64'h0,                1, 0);
        vecs[21] = mkv(32'hFFFFF097, 5'd1,  C_AUIPC,  32'hFFFFF000, 0, 0, C_AUIPC,   64'hFFFFFFFFFFFFF000, 0, 0);
        vecs[22] = mkv(32'h0220803B, 5'd0,  C_NONE,   32'h0,        1, 0, C_OP32,    64'h0,                0, 1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_pc32 = 32'h0000_1000; in_pc64 = 64'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid32", 64'(a_out_valid), 64'd0);
        chk("reset out_valid64", 64'(b_out_valid), 64'd0);
        chk("reset out_cls32",   64'(a_cls), 64'd0);
        chk("reset out_imm64",   b_imm, 64'd0);
        chk("reset out_illegal", 64'(a_illegal), 64'd0);
        chk("reset in_ready32",  64'(a_in_ready), 64'd1);
        chk("reset in_ready64",  64'(b_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream: each vector emerges one edge after it is offered.
        for (int i = 0; i < 23; i++) begin
            logic [31:0] pc_sent;
            drive(1'b1, vecs[i].instr);
            pc_sent = in_pc32;
            @(posedge clk);
            #1;
            $display("vec %0d instr=%h cls32=%h imm32=%h ill32=%0d cls64=%h imm64=%h ill64=%0d md64=%0d",
                     i, vecs[i].instr, a_cls, a_imm, a_illegal, b_cls, b_imm, b_illegal, b_muldiv);
            chk($sformatf("v%0d out_valid", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("v%0d pc32", i),      64'(a_pc), 64'(pc_sent));
            chk($sformatf("v%0d rd32", i),      64'(a_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d cls32", i),     64'(a_cls), 64'(vecs[i].cls32));
            chk($sformatf("v%0d imm32", i),     64'(a_imm), 64'(vecs[i].imm32));
            chk($sformatf("v%0d ill32", i),     64'(a_illegal), 64'(vecs[i].ill32));
            chk($sformatf("v%0d md32", i),      64'(a_muldiv), 64'(vecs[i].md32));
            chk($sformatf("v%0d cls64", i),     64'(b_cls), 64'(vecs[i].cls64));
            chk($sformatf("v%0d imm64", i),     b_imm, vecs[i].imm64);
            chk($sformatf("v%0d ill64", i),     64'(b_illegal), 64'(vecs[i].ill64));
            chk($sformatf("v%0d md64", i),      64'(b_muldiv), 64'(vecs[i].md64));
        end
        drive(1'b0, 32'h0);
        @(posedge clk); #1;
        check_out("drain", 1'b0, 0, 1'b1);

        // Backpressure: two accepts fill main+skid, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, addi_k(1));
        @(posedge clk); #1; $display("bp cycle1 rd=%0d in_ready=%0d", a_rd, a_in_ready);
        check_out("bp1", 1'b1, 1, 1'b1);
        drive(1'b1, addi_k(2));
        @(posedge clk); #1; $display("bp cycle2 rd=%0d in_ready=%0d", a_rd, a_in_ready);
        check_out("bp2", 1'b1, 1, 1'b0);
        drive(1'b1, addi_k(3));
        @(posedge clk); #1; $display("bp cycle3 rd=%0d in_ready=%0d", a_rd, a_in_ready);
        check_out("bp3 stall", 1'b1, 1, 1'b0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; $display("bp cycle4 rd=%0d in_ready=%0d", a_rd, a_in_ready);
        check_out("bp4", 1'b1, 2, 1'b1);
        @(posedge clk); #1; $display("bp cycle5 rd=%0d", a_rd);
        check_out("bp5", 1'b1, 3, 1'b1);
        drive(1'b1, addi_k(4));
        @(posedge clk); #1; $display("bp cycle6 rd=%0d", a_rd);
        check_out("bp6", 1'b1, 4, 1'b1);
        drive(1'b0, 32'h0);
        @(posedge clk); #1;
        check_out("bp7 empty", 1'b0, 0, 1'b1);

        // Flush with main and skid both full.
        out_ready = 1'b0;
        drive(1'b1, addi_k(5));
        drive(1'b1, addi_k(6));
        drive(1'b1, addi_k(7));
        flush = 1'b1;
        @(posedge clk); #1; $display("flush-full out_valid=%0d in_ready=%0d", a_out_valid, a_in_ready);
        check_out("flush full", 1'b0, 0, 1'b1);
        drive(1'b1, addi_k(8));
        flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; $display("post-flush rd=%0d", a_rd);
        check_out("post flush", 1'b1, 8, 1'b1);
        drive(1'b0, 32'h0);
        @(posedge clk); #1;
        check_out("post flush alone", 1'b0, 0, 1'b1);

        // Flush in the same cycle an input is accepted: that input is dropped.
        out_ready = 1'b0;
        drive(1'b1, addi_k(9));
        drive(1'b1, addi_k(10));
        flush = 1'b1;
        @(posedge clk); #1; $display("flush-accept out_valid=%0d", a_out_valid);
        check_out("flush accept", 1'b0, 0, 1'b1);
        drive(1'b0, 32'h0);
        flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("flush discard", 1'b0, 0, 1'b1);

        // Reset mid-stream with both entries held.
        out_ready = 1'b0;
        drive(1'b1, addi_k(11));
        drive(1'b1, addi_k(12));
        rst_n = 1'b0;
        @(posedge clk); #1; $display("mid reset out_valid=%0d cls=%h imm=%h", a_out_valid, a_cls, a_imm);
        check_out("mid reset", 1'b0, 0, 1'b1);
        chk("mid reset cls32", 64'(a_cls), 64'd0);
        chk("mid reset imm32", 64'(a_imm), 64'd0);
        chk("mid reset cls64", 64'(b_cls), 64'd0);
        chk("mid reset illegal", 64'(a_illegal), 64'd0);
        drive(1'b1, addi_k(13));
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; $display("after reset rd=%0d", a_rd);
        check_out("resume", 1'b1, 13, 1'b1);
        drive(1'b0, 32'h0);
        @(posedge clk); #1;
        check_out("resume empty", 1'b0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
